// File: rtl/mult_booth_param.sv
`default_nettype none
// ============================================================================
// Module   : mult_booth_param
// Purpose  : Sequential radix-2 Booth multiplier, N-bit signed/unsigned operands
// Revision : 1.0
// ============================================================================
module mult_booth_param #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             modo,
    input  logic [N-1:0]     valorQ,
    input  logic [N-1:0]     valorM,
    output logic [2*N-1:0]   producto,
    output logic             fin,
    output logic             ocupado
);
    // One guard bit lets unsigned operands run through the signed Booth recoding.
    localparam int W  = N + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W:0]      r_a;
    logic [W-1:0]    r_m;
    logic [W-1:0]    r_q;
    logic            r_q1;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    w_ext_q;
    logic [W-1:0]    w_ext_m;
    logic [W:0]      w_m_wide;
    logic [W:0]      w_sum;
    logic [2*N-1:0]  w_prod;

    assign w_ext_q  = {~modo & valorQ[N-1], valorQ};
    assign w_ext_m  = {~modo & valorM[N-1], valorM};
    assign w_m_wide = {r_m[W-1], r_m};
    // Low 2N bits of {A,Q}: all of Q plus the bottom N-1 bits of A.
    assign w_prod   = {r_a[N-2:0], r_q};

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + w_m_wide;
            2'b10:   w_sum = r_a - w_m_wide;
            default: w_sum = r_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_q1     <= 1'b0;
            r_cnt    <= '0;
            producto <= '0;
            fin      <= 1'b0;
            ocupado  <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= w_ext_m;
                        r_q     <= w_ext_q;
                        r_a     <= '0;
                        r_q1    <= 1'b0;
                        r_cnt   <= CW'(W);
                        ocupado <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_a   <= {w_sum[W], w_sum[W:1]};
                    r_q   <= {w_sum[0], r_q[W-1:1]};
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    producto <= w_prod;
                    fin      <= 1'b1;
                    ocupado  <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
